memory_arbiter: RTL
===================

Name: memory_arbiter

Overview:
- Two-port arbiter that shares the single-ported Memory peripheral between the instruction-fetch port (I) and the load/store port (D) of the core.
- Registers each request and drives the memory for exactly one transaction at a time.
- Waits for memory_response, captures read data while memory_read is still held, then returns a one-cycle response pulse to the winning requester.
- Round-robin on ties; a watchdog timeout returns an error if the memory never responds.

Parameters:
- TIMEOUT_CYCLES, 15, WAIT cycles without memory_response before an error response is returned; 0 disables the timeout.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- i_read  input  1  instruction-fetch request, level, held until i_response
- i_address  input  32  fetch address
- i_response  output  1  one-cycle completion pulse to the I port
- i_error  output  1  valid with i_response; 1 = timeout
- i_read_data  output  32  fetched word, valid with i_response
- d_read  input  1  load request, level, held until d_response
- d_write  input  1  store request, level, held until d_response
- d_option  input  3  access size/sign, passed through to the memory
- d_address  input  32  load/store address
- d_write_data  input  32  store data
- d_response  output  1  one-cycle completion pulse to the D port
- d_error  output  1  valid with d_response; 1 = timeout
- d_read_data  output  32  load data, valid with d_response
- memory_read  output  1  memory read strobe
- memory_write  output  1  memory write strobe
- option  output  3  memory access option
- address  output  32  memory address
- write_data  output  32  memory write data
- memory_response  input  1  registered memory acknowledge
- read_data  input  32  memory read data, combinational while memory_read=1

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset, including reset mid-transaction:
  - state=IDLE.
  - All outputs 0.
  - last_grant=D.
  - Timeout counter 0.
  - Any in-flight transaction is dropped with no response.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Only I requesting: grant I.
  - Only D requesting (d_read or d_write): grant D.
  - Both requesting: grant the port that is not last_grant; update last_grant.
  - On grant, latch address, option and write_data, plus a rw flag.
  - I transactions always use option=3'b010, write_data=0, rw=read.
  - D with d_write=1 is a write regardless of d_read.
  - Go to ISSUE. No request: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - Drive latched address, option and write_data.
  - Read: memory_read=1. Write: memory_write=1.
  - Go to WAIT; clear the timeout counter.
- WAIT:
  - Reads keep memory_read=1 with address held; writes drive memory_write=0 and memory_read=0, so a write is never repeated.
  - memory_response=1: capture read_data (0 for writes), error=0, go to RESP.
  - Otherwise increment the counter. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES: captured data=0, error=1, go to RESP.
- RESP (exactly 1 cycle):
  - memory_read=0, memory_write=0.
  - Granted port's *_response=1, with *_read_data and *_error from the registered capture.
  - Requests are ignored in RESP; next state is IDLE. The requester must drop its request by the following cycle.
- Latency with memory_response one cycle after the strobe:
  - Request seen in IDLE cycle N.
  - ISSUE at N+1, WAIT at N+2, response pulse at N+3.
  - 4-cycle occupancy per transaction.
- Memory-side outputs are registered; address, option and write_data hold their latched values through WAIT and RESP and are 0 after reset.
- The non-granted port's response, error and read_data stay 0.
- memory_response is only sampled in WAIT; a stale response in IDLE, ISSUE or RESP is ignored.
- A request arriving while busy waits in place; no request is ever lost or duplicated.

Test Plan:
- Reset asserted mid-WAIT of an I read at 0x40 -> all outputs 0 asynchronously; after release no i_response is issued; state IDLE.
- Single I read at 0x00000010, memory holds 0xDEADBEEF at word 4:
  - memory_read=1 for 2 cycles, option=3'b010.
  - i_response pulse 3 cycles after the request with i_read_data=0xDEADBEEF, i_error=0.
- D write at 0x20, d_write_data=0x12345678, d_option=3'b010:
  - memory_write high exactly 1 cycle; memory_read never 1.
  - d_response pulse; a subsequent D read at 0x20 returns 0x12345678.
- I and D both requesting continuously from reset:
  - Grants alternate I, D, I, D.
  - Four responses in 16 cycles; each port receives only its own data.
- memory_response tied to 0, TIMEOUT_CYCLES=15, D read at 0x100:
  - d_response occurs 15 WAIT cycles later with d_error=1, d_read_data=0.
  - The next I request is then served normally.
- D read at 0x3 with d_option=3'b000, memory byte 0x80 -> option=3'b000 passed through; d_read_data=0xFFFFFF80.

Source files
------------

// File: rtl/memory_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter in front of a single-ported
// memory. One transaction in flight at a time: IDLE -> ISSUE -> WAIT -> RESP.
// Ties are broken round-robin; a watchdog turns a silent memory into an error.
module memory_arbiter #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    // instruction-fetch port
    input  logic        i_read,
    input  logic [31:0] i_address,
    output logic        i_response,
    output logic        i_error,
    output logic [31:0] i_read_data,
    // load/store port
    input  logic        d_read,
    input  logic        d_write,
    input  logic [2:0]  d_option,
    input  logic [31:0] d_address,
    input  logic [31:0] d_write_data,
    output logic        d_response,
    output logic        d_error,
    output logic [31:0] d_read_data,
    // memory side
    output logic        memory_read,
    output logic        memory_write,
    output logic [2:0]  option,
    output logic [31:0] address,
    output logic [31:0] write_data,
    input  logic        memory_response,
    input  logic [31:0] read_data
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    // Latched copy of the granted request; drives the memory bus directly.
    typedef struct packed {
        logic [31:0] address;
        logic [2:0]  option;
        logic [31:0] write_data;
        logic        write;
    } mem_req_t;

    state_t          state_q, state_d;
    port_t           last_q, last_d;
    port_t           owner_q, owner_d;
    port_t           pick;
    mem_req_t        req_q, req_d;
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_next;
    logic            rsp_q, rsp_d;
    logic            err_q, err_d;
    logic [31:0]     data_q, data_d;
    logic            i_req, d_req;

    assign i_req    = i_read;
    assign d_req    = d_read | d_write;
    assign cnt_next = cnt_q + CW'(1);

    // Next-state and next-value logic for every register in the block.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        req_d   = req_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        rsp_d   = 1'b0;
        err_d   = 1'b0;
        data_d  = '0;
        pick    = PORT_I;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    if (i_req && d_req)
                        pick = (last_q == PORT_I) ? PORT_D : PORT_I;
                    else
                        pick = i_req ? PORT_I : PORT_D;
                    owner_d = pick;
                    last_d  = pick;
                    if (pick == PORT_I) begin
                        // fetches are always plain word reads
                        req_d.address    = i_address;
                        req_d.option     = 3'b010;
                        req_d.write_data = '0;
                        req_d.write      = 1'b0;
                    end else begin
                        // a store wins over a load if both strobes are up
                        req_d.address    = d_address;
                        req_d.option     = d_option;
                        req_d.write_data = d_write_data;
                        req_d.write      = d_write;
                    end
                    rd_d    = ~req_d.write;
                    wr_d    = req_d.write;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // write strobe lasts one cycle so the store is never repeated
                wr_d    = 1'b0;
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (memory_response) begin
                    rd_d    = 1'b0;
                    rsp_d   = 1'b1;
                    data_d  = req_q.write ? 32'h0 : read_data;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_next;
                    if (TIMEOUT_CYCLES != 0 && cnt_next == TO_LIMIT) begin
                        rd_d    = 1'b0;
                        rsp_d   = 1'b1;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= PORT_D;
            owner_q <= PORT_I;
            req_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            rsp_q   <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            req_q   <= req_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            rsp_q   <= rsp_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    assign memory_read  = rd_q;
    assign memory_write = wr_q;
    assign address      = req_q.address;
    assign option       = req_q.option;
    assign write_data   = req_q.write_data;

    // err_q/data_q are zero outside RESP, so only the owner sees a value.
    assign i_response  = rsp_q & (owner_q == PORT_I);
    assign i_error     = err_q & (owner_q == PORT_I);
    assign i_read_data = (owner_q == PORT_I) ? data_q : 32'h0;
    assign d_response  = rsp_q & (owner_q == PORT_D);
    assign d_error     = err_q & (owner_q == PORT_D);
    assign d_read_data = (owner_q == PORT_D) ? data_q : 32'h0;

endmodule
